// File: rtl/dmem_arb_pkg.sv
// Shared constants and the response-tag type for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam logic        PORT_CPU       = 1'b0;
    localparam logic        PORT_DBG       = 1'b1;
    localparam logic [31:0] OOR_RDATA_DFLT = 32'hDEADBEEF;

    typedef struct packed {
        logic valid;
        logic port;
        logic is_read;
        logic oor;
    } rsp_tag_t;

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-way round-robin grant with the last_grant pointer; resets so port 0 wins the first conflict.
module dmem_arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_grant_r;

    // Grant selection: a lone requester wins, a conflict goes to the port not served last.
    always_comb begin
        grant     = 2'b00;
        grant_idx = PORT_CPU;
        case (req_valid)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = PORT_CPU;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = PORT_DBG;
            end
            2'b11: begin
                if (last_grant_r == PORT_DBG) begin
                    grant     = 2'b01;
                    grant_idx = PORT_CPU;
                end else begin
                    grant     = 2'b10;
                    grant_idx = PORT_DBG;
                end
            end
            default: begin
                grant     = 2'b00;
                grant_idx = PORT_CPU;
            end
        endcase
    end

    // Pointer register: remembers the most recently accepted port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= PORT_DBG;
        end else if (grant != 2'b00) begin
            last_grant_r <= grant_idx;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0) and debug (port 1).
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          AW          = 10,
    parameter logic [31:0] OOR_RDATA   = OOR_RDATA_DFLT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_addr,
    input  logic [31:0]   req0_wdata,
    input  logic [3:0]    req0_wen,
    output logic          rsp0_valid,
    output logic [31:0]   rsp0_rdata,
    output logic          rsp0_err,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_addr,
    input  logic [31:0]   req1_wdata,
    input  logic [3:0]    req1_wen,
    output logic          rsp1_valid,
    output logic [31:0]   rsp1_rdata,
    output logic          rsp1_err,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   perf_grant0,
    output logic [31:0]   perf_grant1,
    output logic [31:0]   perf_conflict,
`endif
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wen,
    input  logic [31:0]   mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    logic [1:0]  valid_s;
    logic [1:0]  grant_s;
    logic        grant_idx_s;
    logic        accept_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [3:0]  sel_wen_s;
    logic        in_range_s;
    rsp_tag_t    tag_r;

    function automatic logic [31:0] rsp_data(input rsp_tag_t tag, input logic port,
                                             input logic [31:0] rdata, input logic [31:0] oor_val);
        logic [31:0] d;
        if (tag.valid && (tag.port == port) && tag.is_read) begin
            d = tag.oor ? oor_val : rdata;
        end else begin
            d = 32'h0000_0000;
        end
        return d;
    endfunction

    // Holding reset masks both requests, which forces ready and mem_en low.
    assign valid_s = {req1_valid, req0_valid} & {rst_n, rst_n};

    dmem_arb_rr2 u_rr2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (valid_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];
    assign accept_s   = |grant_s;

    // Request mux and memory drive; out-of-range accesses never strobe the memory.
    always_comb begin
        if (grant_idx_s == PORT_DBG) begin
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
            sel_wen_s   = req1_wen;
        end else begin
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
            sel_wen_s   = req0_wen;
        end
        in_range_s = ({1'b0, sel_addr_s} < ADDR_LIMIT);
        mem_en     = accept_s & in_range_s;
        mem_addr   = sel_addr_s[AW+1:2];
        mem_wdata  = sel_wdata_s;
        if (accept_s && in_range_s) begin
            mem_wen = sel_wen_s;
        end else begin
            mem_wen = 4'h0;
        end
    end

    // Response tag: one-cycle record of the accepted request for the rdata mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r <= '0;
        end else begin
            tag_r.valid   <= accept_s;
            tag_r.port    <= grant_idx_s;
            tag_r.is_read <= (sel_wen_s == 4'h0);
            tag_r.oor     <= ~in_range_s;
        end
    end

    // Response outputs are decoded straight from the tag so data lands exactly one cycle after accept.
    always_comb begin
        rsp0_valid = tag_r.valid & (tag_r.port == PORT_CPU);
        rsp1_valid = tag_r.valid & (tag_r.port == PORT_DBG);
        rsp0_err   = rsp0_valid & tag_r.oor;
        rsp1_err   = rsp1_valid & tag_r.oor;
        rsp0_rdata = rsp_data(tag_r, PORT_CPU, mem_rdata, OOR_RDATA);
        rsp1_rdata = rsp_data(tag_r, PORT_DBG, mem_rdata, OOR_RDATA);
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0_r;
    logic [31:0] perf_grant1_r;
    logic [31:0] perf_conflict_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0_r   <= 32'h0;
            perf_grant1_r   <= 32'h0;
            perf_conflict_r <= 32'h0;
        end else begin
            if (grant_s[0] && (perf_grant0_r != 32'hFFFF_FFFF)) begin
                perf_grant0_r <= perf_grant0_r + 32'd1;
            end else begin
                perf_grant0_r <= perf_grant0_r;
            end
            if (grant_s[1] && (perf_grant1_r != 32'hFFFF_FFFF)) begin
                perf_grant1_r <= perf_grant1_r + 32'd1;
            end else begin
                perf_grant1_r <= perf_grant1_r;
            end
            if ((&valid_s) && (perf_conflict_r != 32'hFFFF_FFFF)) begin
                perf_conflict_r <= perf_conflict_r + 32'd1;
            end else begin
                perf_conflict_r <= perf_conflict_r;
            end
        end
    end

    assign perf_grant0   = perf_grant0_r;
    assign perf_grant1   = perf_grant1_r;
    assign perf_conflict = perf_conflict_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table with a response scoreboard plus reset/perf sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [3:0]  req0_wen, req1_wen;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wen;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wen(req0_wen),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wen(req1_wen),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
`ifdef DMEM_ARB_PERF_EN
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict),
`endif
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory attached to the arbiter.
    logic [31:0] mem_array [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_array[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) mem_array[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  w0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  w1;
        logic [1:0]  eg;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic [31:0] ref_mem [0:1023];
    rsp_t        sb_q [$];
    int          total = 0;
    int          bad = 0;
    vec_t        tbl [16];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [3:0] w0, input logic v1, input logic [31:0] a1,
                                input logic [31:0] d1, input logic [3:0] w1, input logic [1:0] eg);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.w0 = w0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.w1 = w1;
        v.eg = eg;
        return v;
    endfunction

    // Compare whatever response is due this cycle against the scoreboard head.
    task automatic check_rsp();
        rsp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port == 1'b0) begin
                chk("rsp0_valid", 32'(rsp0_valid), 32'd1);
                chk("rsp1_idle", 32'(rsp1_valid), 32'd0);
                chk("rsp0_rdata", rsp0_rdata, e.rdata);
                chk("rsp0_err", 32'(rsp0_err), 32'(e.err));
            end else begin
                chk("rsp1_valid", 32'(rsp1_valid), 32'd1);
                chk("rsp0_idle", 32'(rsp0_valid), 32'd0);
                chk("rsp1_rdata", rsp1_rdata, e.rdata);
                chk("rsp1_err", 32'(rsp1_err), 32'(e.err));
            end
        end else begin
            chk("rsp0_none", 32'(rsp0_valid), 32'd0);
            chk("rsp1_none", 32'(rsp1_valid), 32'd0);
        end
    endtask

    // One cycle: check due response, drive the vector, check grant/memory drive, predict the response.
    task automatic step(input vec_t v);
        logic        idx, rd, inr;
        logic [31:0] a, d;
        logic [3:0]  w;
        rsp_t        e;
        @(negedge clk);
        check_rsp();
        req0_valid = v.v0; req0_addr = v.a0; req0_wdata = v.d0; req0_wen = v.w0;
        req1_valid = v.v1; req1_addr = v.a1; req1_wdata = v.d1; req1_wen = v.w1;
        #1;
        chk("req0_ready", 32'(req0_ready), 32'(v.eg[0]));
        chk("req1_ready", 32'(req1_ready), 32'(v.eg[1]));
        if (v.eg != 2'b00) begin
            idx = v.eg[1];
            a   = idx ? v.a1 : v.a0;
            d   = idx ? v.d1 : v.d0;
            w   = idx ? v.w1 : v.w0;
            rd  = (w == 4'h0);
            inr = (a < 32'h0000_1000);
            chk("mem_en", 32'(mem_en), 32'(inr));
            if (inr) begin
                chk("mem_addr", 32'(mem_addr), 32'(a[11:2]));
                chk("mem_wen", 32'(mem_wen), 32'(w));
                if (!rd) chk("mem_wdata", mem_wdata, d);
            end else begin
                chk("mem_wen_oor", 32'(mem_wen), 32'd0);
            end
            e.port  = idx;
            e.err   = ~inr;
            e.rdata = rd ? (inr ? ref_mem[a[11:2]] : 32'hDEADBEEF) : 32'h0;
            sb_q.push_back(e);
            if (inr && !rd) begin
                for (int b = 0; b < 4; b++) begin
                    if (w[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else begin
            chk("mem_en_idle", 32'(mem_en), 32'd0);
        end
    endtask

    initial begin
        vec_t idle_v, both_v;
        for (int i = 0; i < 1024; i++) begin
            mem_array[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        mem_rdata  = 32'h0;
        req0_valid = 1'b1; req0_addr = 32'h100; req0_wdata = 32'h0; req0_wen = 4'h0;
        req1_valid = 1'b1; req1_addr = 32'h104; req1_wdata = 32'h0; req1_wen = 4'h0;

        // Reset state with both requests pending.
        repeat (2) @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 32'd0);
        chk("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        tbl[0]  = mk(1'b1, 32'h100, 32'h12345678, 4'hF, 1'b1, 32'h104, 32'h0, 4'h0, 2'b01);
        tbl[1]  = mk(1'b1, 32'h200, 32'h0, 4'h0, 1'b1, 32'h104, 32'h0, 4'h0, 2'b10);
        tbl[2]  = mk(1'b1, 32'h200, 32'h0, 4'h0, 1'b1, 32'h104, 32'h11111111, 4'hF, 2'b01);
        tbl[3]  = mk(1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h104, 32'h11111111, 4'hF, 2'b10);
        tbl[4]  = mk(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);
        tbl[5]  = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000, 32'h0, 4'h0, 2'b10);
        tbl[6]  = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 2'b10);
        tbl[7]  = mk(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);
        tbl[8]  = mk(1'b1, 32'h104, 32'hAABBCCDD, 4'h3, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);
        tbl[9]  = mk(1'b1, 32'h104, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);
        tbl[10] = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00);
        tbl[11] = mk(1'b1, 32'h103, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);
        tbl[12] = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFC, 32'h0, 4'h0, 2'b10);
        tbl[13] = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFC, 32'h0, 4'h0, 2'b10);
        tbl[14] = mk(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);
        tbl[15] = mk(1'b1, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01);

        for (int i = 0; i < 16; i++) step(tbl[i]);
        idle_v = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00);
        step(idle_v);
        step(idle_v);

        // Reset while a read is outstanding: the response must vanish.
        step(mk(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01));
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("rst_mid_rsp0", 32'(rsp0_valid), 32'd0);
        chk("rst_mid_rsp1", 32'(rsp1_valid), 32'd0);
        chk("rst_mid_ready0", 32'(req0_ready), 32'd0);
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        both_v = mk(1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h104, 32'h0, 4'h0, 2'b01);
        step(both_v);
        both_v.eg = 2'b10;
        step(both_v);
        step(idle_v);

`ifdef DMEM_ARB_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("perf_rst", perf_grant0 | perf_grant1 | perf_conflict, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            both_v.eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            step(both_v);
        end
        step(idle_v);
        chk("perf_conflict", perf_conflict, 32'd10);
        chk("perf_grant0", perf_grant0, 32'd5);
        chk("perf_grant1", perf_grant1, 32'd5);
`endif

        @(negedge clk);
        check_rsp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters.
- Port 0 is the CPU data port; port 1 is the debug/loader port used by benches and the program loader to poke and peek data memory.
- Round-robin arbitration with a single-beat valid/ready request handshake and a fixed one-cycle response.
- Sits between cpu_top's d_mem_* signals and the data memory array.

Parameters:
DEPTH_WORDS, 1024, memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
AW, 10, word-index width, equal to clog2(DEPTH_WORDS)
OOR_RDATA, 32'hDEADBEEF, read data returned for out-of-range reads

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  CPU request valid
req0_ready  out  1  CPU request accepted this cycle
req0_addr  in  32  CPU byte address
req0_wdata  in  32  CPU write data
req0_wen  in  4  CPU byte enables; 0 means read
rsp0_valid  out  1  CPU response valid
rsp0_rdata  out  32  CPU read data
rsp0_err  out  1  CPU access was out of range
req1_valid, req1_ready, req1_addr, req1_wdata, req1_wen, rsp1_valid, rsp1_rdata, rsp1_err  same as port 0, debug requester
mem_en  out  1  memory access strobe
mem_addr  out  AW  memory word index
mem_wdata  out  32  memory write data
mem_wen  out  4  memory byte write enables
mem_rdata  in  32  memory read data, valid the cycle after mem_en

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- While rst_n=0:
  - rsp*_valid=0, rsp*_rdata=0, rsp*_err=0.
  - The round-robin pointer last_grant=1, so port 0 wins the first conflict.
  - req*_ready=0 and mem_en=0, combinationally forced.
- Grant (combinational):
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to last_grant is granted.
  - Only the granted port sees ready=1; at most one accept per cycle.
- On each accept, last_grant is updated to the granted index.
- Mem drive (combinational from the granted request):
  - mem_addr = addr[AW+1:2]; addr[1:0] is ignored, with no alignment check.
  - mem_wdata and mem_wen pass through.
  - mem_en=1 only when the request is accepted and addr < 4*DEPTH_WORDS.
- Out of range:
  - mem_en=0 and mem_wen=0, so writes are dropped.
  - The request is still accepted and still gets a response with err=1.
- Response: every accepted request produces exactly one response, exactly one cycle later, on the same port:
  - rsp_valid pulses for one cycle.
  - Read in range: rdata=mem_rdata.
  - Read out of range: rdata=OOR_RDATA.
  - Write: rdata=0.
  - err is registered alongside.
- Response bookkeeping: a registered tag {valid, port, is_read, oor} is captured at accept. The following cycle's rdata mux uses the tag.
- Responses cannot be back-pressured.
- Back-to-back accepts:
  - The pointer alternates under continuous contention, so each port gets 50% of cycles.
  - A single active port may issue every cycle, giving 100% throughput.
- Reset mid-operation: an outstanding response is discarded (rsp_valid stays 0), and the pointer returns to its reset value.
- Requesters must hold addr, wdata and wen stable while valid=1 and ready=0.

Optional Feature:
Macro: DMEM_ARB_PERF_EN
- Defined: adds outputs perf_grant0 [31:0], perf_grant1 [31:0] and perf_conflict [31:0].
  - perf_grant0 / perf_grant1 count accepts per port.
  - perf_conflict counts cycles where both ports are valid.
  - Counters reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the ports and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - constants PORT_CPU=0 and PORT_DBG=1;
  - OOR_RDATA default;
  - the response-tag typedef {valid, port, is_read, oor}.
- One sub-module, dmem_arb_rr2: the 2-way round-robin grant logic plus the last_grant register.

Test Plan:
- Solo access, port 0 write: addr=0x100, wdata=0x12345678, wen=4'hF; then read 0x100.
  - Required: mem_en pulse with mem_addr=64.
  - rsp0_valid one cycle after each accept.
  - Read returns rdata=0x12345678, err=0.
- Contention, both ports valid for 4 cycles starting right after reset:
  - Grant order must be 0,1,0,1.
  - Each response appears on its own port one cycle after its accept.
- Out-of-range address, port 1 read of 0x1000:
  - No mem_en.
  - rsp1_valid=1, rsp1_rdata=0xDEADBEEF, rsp1_err=1.
  - A write to 0x1000 leaves memory untouched.
- Byte enable: write 0xAABBCCDD with wen=4'h3 over an existing word 0x11111111.
  - Read back must return 0x1111CCDD.
- Reset during an outstanding read: deassert rst_n in the cycle after the accept.
  - No rsp_valid is ever seen.
  - After release, port 0 wins the first conflict.
- With DMEM_ARB_PERF_EN defined: 10 cycles of dual-valid requests.
  - perf_conflict=10, perf_grant0=5, perf_grant1=5.
